// File: rtl/inv_sub_bytes_gf.sv
// Iterative AES InvSubBytes: inverse affine, then x^254 in GF(2^8), LANES bytes per 9-cycle pass.
// Latency 9*(16/LANES) cycles after accept; in_ready low until the result is taken via out_ready.
module inv_sub_bytes_gf #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_gf: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int         G     = 16 / LANES;
    localparam logic [3:0] GLAST = 4'(G - 1);
    localparam logic [7:0] EXPO  = 8'hFE;

    typedef enum logic [1:0] {S_IDLE, S_AFFINE, S_EXP, S_DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] in_buf;
    logic [3:0]   group;
    logic [2:0]   step;
    logic [7:0]   op       [LANES];
    logic [7:0]   acc      [LANES];
    logic [7:0]   acc_next [LANES];

    function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = S_AFFINE;
            S_AFFINE: state_nxt = S_EXP;
            S_EXP:    if (step == 3'd0) state_nxt = (group == GLAST) ? S_DONE : S_AFFINE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE) && !rst;
        out_valid = (state == S_DONE);
        busy      = (state == S_AFFINE) || (state == S_EXP);
    end

    // One square-and-multiply step of x^254, MSB of the exponent first.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            acc_next[k] = EXPO[step] ? gfmul(gfmul(acc[k], acc[k]), op[k])
                                     : gfmul(acc[k], acc[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf    <= '0;
            out_state <= '0;
            group     <= '0;
            step      <= '0;
            for (int k = 0; k < LANES; k++) begin
                op[k]  <= 8'h00;
                acc[k] <= 8'h00;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_buf <= in_state;
                        group  <= '0;
                    end
                end
                S_AFFINE: begin
                    for (int k = 0; k < LANES; k++) begin
                        op[k]  <= inv_affine(in_buf[(int'(group) * LANES + k) * 8 +: 8]);
                        acc[k] <= 8'h01;
                    end
                    step <= 3'd7;
                end
                S_EXP: begin
                    for (int k = 0; k < LANES; k++) acc[k] <= acc_next[k];
                    if (step == 3'd0) begin
                        for (int k = 0; k < LANES; k++)
                            out_state[(int'(group) * LANES + k) * 8 +: 8] <= acc_next[k];
                        if (group != GLAST) group <= group + 4'd1;
                    end else begin
                        step <= step - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
